// File: rtl/dmem_host_arbiter_pkg.sv
// rtl/dmem_host_arbiter_pkg.sv - shared types and defaults for the data-RAM host arbiter
package dmem_host_arbiter_pkg;

    localparam int DMEM_DATA_W_DEF   = 16;
    localparam int DMEM_ADDR_W_DEF   = 8;
    localparam int DMEM_STATS_W      = 16;
    localparam int DMEM_STATS_LIMIT  = 16'hFFFF;

    typedef enum logic {
        S_CORE     = 1'b0,
        S_COOLDOWN = 1'b1
    } arb_state_e;

    // A zero-wide counter is not legal, so HOST_MAX_WAIT=0 still gets one bit.
    function automatic int wait_cnt_w(input int max_wait);
        if (max_wait < 1) begin
            return 1;
        end
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_wait_counter.sv
// rtl/dmem_arb_wait_counter.sv - saturating up-counter with clear and terminal flag
module dmem_arb_wait_counter #(
    parameter int LIMIT = 3,
    parameter int W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         at_limit_o
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; the count parks at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q == LIMIT_W);

endmodule

// File: rtl/dmem_host_arbiter.sv
// rtl/dmem_host_arbiter.sv - core/host arbiter for the data RAM; optional DMEM_ARB_STATS_EN adds grant/stall counters
module dmem_host_arbiter
    import dmem_host_arbiter_pkg::*;
#(
    parameter int DATA_W        = DMEM_DATA_W_DEF,
    parameter int ADDR_W        = DMEM_ADDR_W_DEF,
    parameter int HOST_MAX_WAIT = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iCoreWriteEnable,
    input  logic [ADDR_W-1:0] iCoreWriteAddress,
    input  logic [DATA_W-1:0] iCoreWriteData,
    input  logic [ADDR_W-1:0] iCoreReadAddress0,
    output logic              oCoreStall,
    input  logic              iHostValid,
    input  logic              iHostWrite,
    input  logic [ADDR_W-1:0] iHostAddress,
    input  logic [DATA_W-1:0] iHostWriteData,
    output logic              oHostReady,
    output logic              oHostReadValid,
    output logic [DATA_W-1:0] oHostReadData,
    input  logic [DATA_W-1:0] iRamReadData0,
    output logic              oRamWriteEnable,
    output logic [ADDR_W-1:0] oRamWriteAddress,
    output logic [DATA_W-1:0] oRamWriteData,
    output logic [ADDR_W-1:0] oRamReadAddress0
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       oHostGrantCount,
    output logic [15:0]       oStallCount
`endif
);

    localparam int WAIT_W = wait_cnt_w(HOST_MAX_WAIT);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    logic              host_grant;
    logic              wait_expired;
    logic [WAIT_W-1:0] wait_cnt_unused;

    dmem_arb_wait_counter #(
        .LIMIT (HOST_MAX_WAIT),
        .W     (WAIT_W)
    ) u_wait_cnt (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .clr_i      (host_grant || !iHostValid),
        .inc_i      (iHostValid && !host_grant),
        .count_o    (wait_cnt_unused),
        .at_limit_o (wait_expired)
    );

    // Grant is gated by Reset so the outputs collapse to the idle case while reset is held.
    always_comb begin
        host_grant = 1'b0;
        state_d    = state_q;
        case (state_q)
            S_CORE: begin
                host_grant = Reset && iHostValid && (!iCoreWriteEnable || wait_expired);
                if (host_grant) begin
                    state_d = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                state_d = S_CORE;
            end
            default: begin
                state_d = S_CORE;
            end
        endcase
    end

    always_comb begin
        oHostReady       = host_grant;
        oCoreStall       = host_grant;
        oRamWriteEnable  = iCoreWriteEnable;
        oRamWriteAddress = iCoreWriteAddress;
        oRamWriteData    = iCoreWriteData;
        oRamReadAddress0 = iCoreReadAddress0;
        if (host_grant) begin
            oRamWriteEnable = iHostWrite;
            if (iHostWrite) begin
                oRamWriteAddress = iHostAddress;
                oRamWriteData    = iHostWriteData;
            end else begin
                oRamReadAddress0 = iHostAddress;
            end
        end
    end

    // Read data is captured at the end of the grant cycle and held until the next host read.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (host_grant && !iHostWrite) begin
            rd_valid_d = 1'b1;
            rd_data_d  = iRamReadData0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_CORE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign oHostReadValid = rd_valid_q;
    assign oHostReadData  = rd_data_q;

`ifdef DMEM_ARB_STATS_EN
    logic grant_sat_unused;
    logic stall_sat_unused;

    dmem_arb_wait_counter #(
        .LIMIT (DMEM_STATS_LIMIT),
        .W     (DMEM_STATS_W)
    ) u_grant_cnt (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .clr_i      (1'b0),
        .inc_i      (host_grant),
        .count_o    (oHostGrantCount),
        .at_limit_o (grant_sat_unused)
    );

    dmem_arb_wait_counter #(
        .LIMIT (DMEM_STATS_LIMIT),
        .W     (DMEM_STATS_W)
    ) u_stall_cnt (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .clr_i      (1'b0),
        .inc_i      (oCoreStall),
        .count_o    (oStallCount),
        .at_limit_o (stall_sat_unused)
    );
`endif

endmodule

// File: tb/tb_dmem_host_arbiter.sv
// tb/tb_dmem_host_arbiter.sv - self-checking bench for dmem_host_arbiter
module tb_dmem_host_arbiter;

    localparam int MAXW = 3;

    logic        Clock;
    logic        Reset;
    logic        iCoreWriteEnable;
    logic [7:0]  iCoreWriteAddress;
    logic [15:0] iCoreWriteData;
    logic [7:0]  iCoreReadAddress0;
    logic        oCoreStall;
    logic        iHostValid;
    logic        iHostWrite;
    logic [7:0]  iHostAddress;
    logic [15:0] iHostWriteData;
    logic        oHostReady;
    logic        oHostReadValid;
    logic [15:0] oHostReadData;
    logic [15:0] iRamReadData0;
    logic        oRamWriteEnable;
    logic [7:0]  oRamWriteAddress;
    logic [15:0] oRamWriteData;
    logic [7:0]  oRamReadAddress0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] oHostGrantCount;
    logic [15:0] oStallCount;
`endif

    int vectors;
    int miscompares;
    logic [15:0] exp_rd;
    logic [15:0] mem [256];

    dmem_host_arbiter #(
        .DATA_W        (16),
        .ADDR_W        (8),
        .HOST_MAX_WAIT (MAXW)
    ) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .iCoreWriteEnable  (iCoreWriteEnable),
        .iCoreWriteAddress (iCoreWriteAddress),
        .iCoreWriteData    (iCoreWriteData),
        .iCoreReadAddress0 (iCoreReadAddress0),
        .oCoreStall        (oCoreStall),
        .iHostValid        (iHostValid),
        .iHostWrite        (iHostWrite),
        .iHostAddress      (iHostAddress),
        .iHostWriteData    (iHostWriteData),
        .oHostReady        (oHostReady),
        .oHostReadValid    (oHostReadValid),
        .oHostReadData     (oHostReadData),
        .iRamReadData0     (iRamReadData0),
        .oRamWriteEnable   (oRamWriteEnable),
        .oRamWriteAddress  (oRamWriteAddress),
        .oRamWriteData     (oRamWriteData),
        .oRamReadAddress0  (oRamReadAddress0)
`ifdef DMEM_ARB_STATS_EN
        ,
        .oHostGrantCount   (oHostGrantCount),
        .oStallCount       (oStallCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM model: combinational read port 0, synchronous write port
    assign iRamReadData0 = mem[oRamReadAddress0];
    always @(posedge Clock) begin
        if (oRamWriteEnable) mem[oRamWriteAddress] <= oRamWriteData;
    end

    task automatic idle_inputs();
        iCoreWriteEnable  = 1'b0;
        iCoreWriteAddress = 8'h00;
        iCoreWriteData    = 16'h0000;
        iCoreReadAddress0 = 8'h00;
        iHostValid        = 1'b0;
        iHostWrite        = 1'b0;
        iHostAddress      = 8'h00;
        iHostWriteData    = 16'h0000;
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] want;
        logic [59:0] outs;
        #3;
        outs = {oHostReady, oCoreStall, oRamWriteEnable, oRamWriteAddress, oRamWriteData,
                oRamReadAddress0, oHostReadValid, oHostReadData};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h want 0", outs);
        end
        next_cycle();
        #2 Reset = 1'b1;
        next_cycle();
        iHostValid   = 1'b1;
        iHostWrite   = 1'b0;
        iHostAddress = 8'h22;
        @(negedge Clock);
        vectors++;
        if (oHostReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_grant: got %b want 1", oHostReady);
        end
        #1 Reset = 1'b0;
        #1;
        outs = {oHostReady, oCoreStall, oRamWriteEnable, oRamWriteAddress, oRamWriteData,
                oRamReadAddress0, oHostReadValid, oHostReadData};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_transfer: got %h want 0", outs);
        end
        next_cycle();
        iHostValid = 1'b0;
        @(negedge Clock);
        #1 Reset = 1'b1;
        next_cycle();
        vectors++;
        if (oHostReadValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_pulse: got %b want 0", oHostReadValid);
        end
        iHostValid   = 1'b1;
        iHostWrite   = 1'b0;
        iHostAddress = 8'h22;
        @(negedge Clock);
        want = mem[8'h22];
        vectors++;
        if (oHostReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state_core: got %b want 1", oHostReady);
        end
        next_cycle();
        iHostValid = 1'b0;
        @(negedge Clock);
        vectors++;
        if ({oHostReadValid, oHostReadData} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL reset_first_read: got %b/%h want 1/%h", oHostReadValid, oHostReadData, want);
        end
        exp_rd = want;
        next_cycle();
    endtask

    task automatic test_host_write();
        idle_inputs();
        iHostValid     = 1'b1;
        iHostWrite     = 1'b1;
        iHostAddress   = 8'h10;
        iHostWriteData = 16'hBEEF;
        @(negedge Clock);
        vectors++;
        if ({oHostReady, oRamWriteEnable, oRamWriteAddress, oRamWriteData, oCoreStall}
                !== {1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b1}) begin
            miscompares++;
            $display("FAIL host_write_grant: got rdy=%b we=%b a=%h d=%h st=%b want 1 1 10 beef 1",
                     oHostReady, oRamWriteEnable, oRamWriteAddress, oRamWriteData, oCoreStall);
        end
        next_cycle();
        @(negedge Clock);
        vectors++;
        if ({oHostReady, oCoreStall, oRamWriteEnable} !== 3'b000) begin
            miscompares++;
            $display("FAIL host_write_cooldown: got rdy=%b st=%b we=%b want 0 0 0",
                     oHostReady, oCoreStall, oRamWriteEnable);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        vectors++;
        if (mem[8'h10] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL host_write_ram: got %h want beef", mem[8'h10]);
        end
    endtask

    task automatic test_max_wait();
        idle_inputs();
        iHostWrite     = 1'b1;
        iHostAddress   = 8'h30;
        iHostWriteData = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            iCoreWriteEnable  = 1'b1;
            iCoreWriteAddress = 8'h40 + 8'(i);
            iCoreWriteData    = 16'hA000 + 16'(i);
            iHostValid        = (i <= 3);
            @(negedge Clock);
            vectors++;
            if ({oHostReady, oCoreStall, oRamWriteAddress} !==
                    {(i == 3), (i == 3), (i == 3) ? 8'h30 : 8'h40 + 8'(i)}) begin
                miscompares++;
                $display("FAIL max_wait_cycle%0d: got rdy=%b st=%b a=%h", i,
                         oHostReady, oCoreStall, oRamWriteAddress);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_host_read();
        idle_inputs();
        mem[8'h05]        = 16'h1234;
        iHostValid        = 1'b1;
        iHostWrite        = 1'b0;
        iHostAddress      = 8'h05;
        iCoreReadAddress0 = 8'h77;
        @(negedge Clock);
        vectors++;
        if ({oHostReady, oRamWriteEnable, oRamReadAddress0} !== {1'b1, 1'b0, 8'h05}) begin
            miscompares++;
            $display("FAIL host_read_grant: got rdy=%b we=%b ra=%h want 1 0 05",
                     oHostReady, oRamWriteEnable, oRamReadAddress0);
        end
        next_cycle();
        iHostValid = 1'b0;
        @(negedge Clock);
        vectors++;
        if ({oHostReadValid, oHostReadData, oRamReadAddress0} !== {1'b1, 16'h1234, 8'h77}) begin
            miscompares++;
            $display("FAIL host_read_pulse: got v=%b d=%h ra=%h want 1 1234 77",
                     oHostReadValid, oHostReadData, oRamReadAddress0);
        end
        next_cycle();
        @(negedge Clock);
        vectors++;
        if ({oHostReadValid, oHostReadData} !== {1'b0, 16'h1234}) begin
            miscompares++;
            $display("FAIL host_read_hold: got v=%b d=%h want 0 1234", oHostReadValid, oHostReadData);
        end
        exp_rd = 16'h1234;
        next_cycle();
    endtask

    task automatic test_alternate();
        idle_inputs();
        iHostValid     = 1'b1;
        iHostWrite     = 1'b1;
        iHostAddress   = 8'($urandom);
        iHostWriteData = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            vectors++;
            if (oHostReady !== ((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL alternate_cycle%0d: got %b want %b", i, oHostReady, (i % 2) == 0);
            end
            if (oHostReady) begin
                next_cycle();
                iHostAddress   = 8'($urandom);
                iHostWriteData = 16'($urandom);
            end else begin
                next_cycle();
            end
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random();
        bit          pend;
        bit          m_cool;
        bit          m_rv;
        int          m_lost;
        bit          g;
        bit          e_we;
        logic [7:0]  e_wa;
        logic [15:0] e_wd;
        logic [7:0]  e_ra;
        pend   = 1'b0;
        m_cool = 1'b0;
        m_rv   = 1'b0;
        m_lost = 0;
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            if (!pend && ($urandom_range(0, 2) != 0)) begin
                pend           = 1'b1;
                iHostWrite     = 1'($urandom_range(0, 1));
                iHostAddress   = 8'($urandom);
                iHostWriteData = 16'($urandom);
            end
            iHostValid        = pend;
            iCoreWriteEnable  = ($urandom_range(0, 3) != 0);
            iCoreWriteAddress = 8'($urandom);
            iCoreWriteData    = 16'($urandom);
            iCoreReadAddress0 = 8'($urandom);
            @(negedge Clock);
            g    = !m_cool && pend && (!iCoreWriteEnable || m_lost == MAXW);
            e_we = g ? iHostWrite : iCoreWriteEnable;
            e_wa = (g && iHostWrite) ? iHostAddress : iCoreWriteAddress;
            e_wd = (g && iHostWrite) ? iHostWriteData : iCoreWriteData;
            e_ra = (g && !iHostWrite) ? iHostAddress : iCoreReadAddress0;
            vectors++;
            if ({oHostReady, oCoreStall, oRamWriteEnable} !== {g, g, e_we}) begin
                miscompares++;
                $display("FAIL rand_ctrl n=%0d: got rdy=%b st=%b we=%b want %b %b %b", n,
                         oHostReady, oCoreStall, oRamWriteEnable, g, g, e_we);
            end
            if (e_we) begin
                vectors++;
                if ({oRamWriteAddress, oRamWriteData} !== {e_wa, e_wd}) begin
                    miscompares++;
                    $display("FAIL rand_wr n=%0d: got %h/%h want %h/%h", n,
                             oRamWriteAddress, oRamWriteData, e_wa, e_wd);
                end
            end
            if (!(g && iHostWrite)) begin
                vectors++;
                if (oRamReadAddress0 !== e_ra) begin
                    miscompares++;
                    $display("FAIL rand_ra n=%0d: got %h want %h", n, oRamReadAddress0, e_ra);
                end
            end
            vectors++;
            if ({oHostReadValid, oHostReadData} !== {m_rv, exp_rd}) begin
                miscompares++;
                $display("FAIL rand_rd n=%0d: got %b/%h want %b/%h", n,
                         oHostReadValid, oHostReadData, m_rv, exp_rd);
            end
            m_rv = g && !iHostWrite;
            if (m_rv) exp_rd = mem[iHostAddress];
            if (pend && !g) m_lost = (m_lost < MAXW) ? m_lost + 1 : MAXW;
            else            m_lost = 0;
            m_cool = g;
            if (g) pend = 1'b0;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        idle_inputs();
        #2 Reset = 1'b0;
        #2;
        vectors++;
        if ({oHostGrantCount, oStallCount} !== 32'h0) begin
            miscompares++;
            $display("FAIL stats_reset: got %h/%h want 0/0", oHostGrantCount, oStallCount);
        end
        next_cycle();
        Reset = 1'b1;
        next_cycle();
        iHostValid = 1'b1;
        iHostWrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iHostAddress   = 8'($urandom);
            iHostWriteData = 16'($urandom);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        vectors++;
        if ({oHostGrantCount, oStallCount} !== {16'd5, 16'd5}) begin
            miscompares++;
            $display("FAIL stats_count: got %0d/%0d want 5/5", oHostGrantCount, oStallCount);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_rd      = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        Reset = 1'b0;
        idle_inputs();
        test_reset();
        test_host_write();
        test_max_wait();
        test_host_read();
        test_alternate();
        test_random();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
